// File: rtl/pulse_scheduler_pkg.sv
// Shared types and default widths for the pulse scheduler.
package pulse_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, FIRE, GAP} sched_state_t;

  localparam int DEF_CNT_W   = 10;
  localparam int DEF_BURST_W = 8;
endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first pending bit after i_rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);
  // Walk from the farthest offset down so the nearest candidate after the pointer wins.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      int idx;
      idx = (int'(i_rr_ptr) + i) % N_REQ;
      if (i_pending[IDX_W'(idx)]) begin
        o_valid  = 1'b1;
        o_winner = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/pulse_scheduler.sv
// Serialises requester strobes onto one enable line as bursts of one-cycle pulses
// with a programmable holdoff; config is captured per grant.
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic               cfg_enable,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               enable,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic [N_REQ-1:0]   pending,
  output logic [N_REQ-1:0]   overrun
);
  sched_state_t       r_state;
  sched_state_t       w_next_state;
  logic               r_enable;
  logic [IDX_W-1:0]   r_grant_id;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [N_REQ-1:0]   r_pending;
  logic [N_REQ-1:0]   r_overrun;
  logic [CNT_W-1:0]   r_period_q;
  logic [CNT_W-1:0]   r_gap_cnt;
  logic [BURST_W-1:0] r_burst_left;

  logic [IDX_W-1:0]   w_winner;
  logic               w_valid;
  logic               w_take;
  logic [N_REQ-1:0]   w_grant_onehot;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  always_comb begin
    w_next_state   = r_state;
    w_take         = 1'b0;
    w_grant_onehot = '0;
    case (r_state)
      IDLE: begin
        if (cfg_enable && w_valid) begin
          w_take                   = 1'b1;
          w_grant_onehot[w_winner] = 1'b1;
          w_next_state             = FIRE;
        end
      end
      FIRE: begin
        if (r_period_q != '0)
          w_next_state = GAP;
        else if (r_burst_left != '0)
          w_next_state = FIRE;
        else
          w_next_state = IDLE;
      end
      GAP: begin
        if (r_gap_cnt == '0)
          w_next_state = (r_burst_left != '0) ? FIRE : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_enable     <= 1'b0;
      r_grant_id   <= '0;
      r_rr_ptr     <= IDX_W'(N_REQ - 1);
      r_pending    <= '0;
      r_overrun    <= '0;
      r_period_q   <= '0;
      r_gap_cnt    <= '0;
      r_burst_left <= '0;
    end else begin
      r_state   <= w_next_state;
      r_enable  <= (w_next_state == FIRE);
      // A strobe on the bit being granted this cycle re-pends rather than overruns.
      r_pending <= (r_pending & ~w_grant_onehot) | req;
      r_overrun <= r_overrun | (req & r_pending & ~w_grant_onehot);

      if (w_take) begin
        r_grant_id   <= w_winner;
        r_rr_ptr     <= w_winner;
        r_period_q   <= cfg_period;
        r_burst_left <= cfg_burst;
      end

      case (r_state)
        FIRE: begin
          if (r_period_q != '0)
            r_gap_cnt <= r_period_q - 1'b1;
          else if (r_burst_left != '0)
            r_burst_left <= r_burst_left - 1'b1;
        end
        GAP: begin
          if (r_gap_cnt != '0)
            r_gap_cnt <= r_gap_cnt - 1'b1;
          else if (r_burst_left != '0)
            r_burst_left <= r_burst_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign enable   = r_enable;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);
  assign pending  = r_pending;
  assign overrun  = r_overrun;
endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed-vector bench for pulse_scheduler; cycle 0 is the cycle the first strobe is driven.
module tb_pulse_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       cfg_enable;
  logic [9:0] cfg_period;
  logic [7:0] cfg_burst;
  logic       enable;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] overrun;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pulse_scheduler #(.N_REQ(4), .CNT_W(10), .BURST_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .cfg_enable (cfg_enable),
    .cfg_period (cfg_period),
    .cfg_burst  (cfg_burst),
    .enable     (enable),
    .grant_id   (grant_id),
    .busy       (busy),
    .pending    (pending),
    .overrun    (overrun)
  );

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    cfg_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    cfg_enable = 1'b1;
    cfg_period = 10'd0;
    cfg_burst  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({enable, busy, grant_id, pending, overrun} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_state: got en=%b busy=%b gid=%0d pend=%b ovr=%b want all zero",
               enable, busy, grant_id, pending, overrun);
    end
    reset = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    cfg_period = 10'd3;
    cfg_burst  = 8'd0;
    for (int c = 0; c < 8; c++) begin
      req = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      vectors++;
      if (enable !== (c == 2) || busy !== (c >= 2 && c <= 5)) begin
        miscompares++;
        $display("FAIL single_en_busy c%0d: got en=%b busy=%b want en=%b busy=%b",
                 c, enable, busy, (c == 2), (c >= 2 && c <= 5));
      end
      if (c == 1 || c == 2) begin
        vectors++;
        if ((c == 1 && pending !== 4'b0100) || (c == 2 && grant_id !== 2'd2)) begin
          miscompares++;
          $display("FAIL single_grant c%0d: got pend=%b gid=%0d want pend=0100 (c1) gid=2 (c2)",
                   c, pending, grant_id);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_burst_shadow();
    do_reset();
    cfg_period = 10'd3;
    cfg_burst  = 8'd2;
    for (int c = 0; c < 16; c++) begin
      req = (c == 0) ? 4'b0001 : 4'b0000;
      if (c == 4) cfg_period = 10'd7;
      @(negedge clk);
      vectors++;
      if (enable !== (c == 2 || c == 6 || c == 10) || busy !== (c >= 2 && c <= 13)) begin
        miscompares++;
        $display("FAIL burst_shadow c%0d: got en=%b busy=%b want en=%b busy=%b",
                 c, enable, busy, (c == 2 || c == 6 || c == 10), (c >= 2 && c <= 13));
      end
      @(posedge clk);
      #1;
    end
    cfg_period = 10'd3;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg_period = 10'd0;
    cfg_burst  = 8'd3;
    for (int c = 0; c < 9; c++) begin
      req = (c == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      vectors++;
      if (enable !== (c >= 2 && c <= 5) || busy !== (c >= 2 && c <= 5)) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got en=%b busy=%b want en=%b busy=%b",
                 c, enable, busy, (c >= 2 && c <= 5), (c >= 2 && c <= 5));
      end
      if (c == 3) begin
        vectors++;
        if (grant_id !== 2'd3) begin
          miscompares++;
          $display("FAIL back_to_back_gid: got %0d want 3", grant_id);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_round_robin();
    logic exp_en;
    do_reset();
    cfg_period = 10'd0;
    cfg_burst  = 8'd0;
    for (int c = 0; c < 11; c++) begin
      req = (c == 0) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      exp_en = (c == 2 || c == 4 || c == 6 || c == 8);
      vectors++;
      if (enable !== exp_en || busy !== exp_en) begin
        miscompares++;
        $display("FAIL rr_en c%0d: got en=%b busy=%b want %b", c, enable, busy, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (grant_id !== 2'((c - 2) / 2)) begin
          miscompares++;
          $display("FAIL rr_gid c%0d: got %0d want %0d", c, grant_id, (c - 2) / 2);
        end
      end
      if (c == 1 || c >= 8) begin
        vectors++;
        if (pending !== ((c == 1) ? 4'b1111 : 4'b0000)) begin
          miscompares++;
          $display("FAIL rr_pending c%0d: got %b want %b", c, pending,
                   (c == 1) ? 4'b1111 : 4'b0000);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_cfg_enable_overrun();
    logic [3:0] exp_pend;
    logic [3:0] exp_ovr;
    do_reset();
    cfg_enable = 1'b0;
    cfg_period = 10'd0;
    cfg_burst  = 8'd0;
    for (int c = 0; c < 8; c++) begin
      req = (c <= 1) ? 4'b0010 : 4'b0000;
      if (c == 3) cfg_enable = 1'b1;
      @(negedge clk);
      exp_pend = (c >= 1 && c <= 3) ? 4'b0010 : 4'b0000;
      exp_ovr  = (c >= 2) ? 4'b0010 : 4'b0000;
      vectors++;
      if (pending !== exp_pend || overrun !== exp_ovr || enable !== (c == 4)) begin
        miscompares++;
        $display("FAIL cfg_en_overrun c%0d: got pend=%b ovr=%b en=%b want pend=%b ovr=%b en=%b",
                 c, pending, overrun, enable, exp_pend, exp_ovr, (c == 4));
      end
      if (c == 4) begin
        vectors++;
        if (grant_id !== 2'd1) begin
          miscompares++;
          $display("FAIL cfg_en_gid: got %0d want 1", grant_id);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cfg_period = 10'd3;
    cfg_burst  = 8'd2;
    for (int c = 0; c < 21; c++) begin
      req   = (c == 0) ? 4'b0001 : ((c == 3 || c == 4) ? 4'b0010 : 4'b0000);
      reset = (c == 7);
      @(negedge clk);
      vectors++;
      if (enable !== (c == 2 || c == 6)) begin
        miscompares++;
        $display("FAIL abort_en c%0d: got %b want %b", c, enable, (c == 2 || c == 6));
      end
      if (c == 6) begin
        vectors++;
        if (pending !== 4'b0010 || overrun !== 4'b0010 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL abort_pre c6: got pend=%b ovr=%b busy=%b want 0010 0010 1",
                   pending, overrun, busy);
        end
      end
      if (c >= 8) begin
        vectors++;
        if (busy !== 1'b0 || pending !== 4'b0 || overrun !== 4'b0) begin
          miscompares++;
          $display("FAIL abort_post c%0d: got busy=%b pend=%b ovr=%b want 0 0000 0000",
                   c, busy, pending, overrun);
        end
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    cfg_enable = 1'b1;
    cfg_period = '0;
    cfg_burst  = '0;
    test_reset();
    test_single();
    test_burst_shadow();
    test_back_to_back();
    test_round_robin();
    test_cfg_enable_overrun();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
